// File: rtl/ssub_rr_arbiter.sv
// One shared signed subtractor time-multiplexed between NUM_REQ requesters.
// Round-robin grant in IDLE, subtract in CALC, hold tagged result in RESP until consumed.
module ssub_rr_arbiter #(
    parameter int DATAWIDTH = 64,
    parameter int NUM_REQ   = 4,
    parameter int IDW       = 2
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [IDW-1:0]                 rsp_id,
    output logic [DATAWIDTH-1:0]           rsp_diff,
    output logic                           rsp_ovf,
    output logic                           busy
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]         op_id_q, op_id_d;
    logic [DATAWIDTH-1:0]   op_a_q, op_a_d;
    logic [DATAWIDTH-1:0]   op_b_q, op_b_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]         rsp_id_q, rsp_id_d;
    logic [DATAWIDTH-1:0]   rsp_diff_q, rsp_diff_d;
    logic                   rsp_ovf_q, rsp_ovf_d;

    logic [IDW-1:0]         grant;
    logic                   grant_vld;
    logic [DATAWIDTH-1:0]   diff;
    logic                   ovf;

    // Requester index k positions after base, wrapping at NUM_REQ.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDW-1:0];
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && req_valid[wrap_idx(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant     = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    // Overflow only possible when operand signs differ and the result sign leaves a's.
    assign diff = op_a_q - op_b_q;
    assign ovf  = (op_a_q[DATAWIDTH-1] != op_b_q[DATAWIDTH-1]) &&
                  (diff[DATAWIDTH-1] != op_a_q[DATAWIDTH-1]);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_id_d     = op_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_diff_d  = rsp_diff_q;
        rsp_ovf_d   = rsp_ovf_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
                    op_a_d    = req_a[grant*DATAWIDTH +: DATAWIDTH];
                    op_b_d    = req_b[grant*DATAWIDTH +: DATAWIDTH];
                    op_id_d   = grant;
                    rr_ptr_d  = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + IDW'(1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                rsp_diff_d  = diff;
                rsp_ovf_d   = ovf;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_id_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_diff_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_id_q     <= op_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_diff_q  <= rsp_diff_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_diff  = rsp_diff_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ssub_rr_arbiter.sv
// Bench for ssub_rr_arbiter: directed scenarios then randomized traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_ssub_rr_arbiter;

    localparam int DW = 64;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam logic signed [DW:0] SMAX = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [DW:0] SMIN = {2'b11, {(DW-1){1'b0}}};

    logic                Clk;
    logic                Rst;
    logic [NR-1:0]       req_valid;
    logic [NR*DW-1:0]    req_a;
    logic [NR*DW-1:0]    req_b;
    logic [NR-1:0]       req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IW-1:0]       rsp_id;
    logic [DW-1:0]       rsp_diff;
    logic                rsp_ovf;
    logic                busy;

    ssub_rr_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR), .IDW(IW)) dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_diff(rsp_diff), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int errors = 0;
    int checks = 0;

    // requester side
    bit            pend [NR];
    logic [DW-1:0] a_r  [NR];
    logic [DW-1:0] b_r  [NR];
    int            wait_cnt [NR];

    // reference model
    int            m_rr;
    bit            m_free, m_pend, m_rv;
    logic [DW-1:0] m_a, m_b, m_diff;
    logic [IW-1:0] m_opid, m_id;
    logic          m_ovf;
    int            obs_gnt;

    int            gq[$];
    int            tq[$];
    int            cyc_no = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int n = 0;
        int idx = -1;
        for (int i = 0; i < NR; i++) if (v[i] === 1'b1) begin n++; idx = i; end
        return (n == 1) ? idx : ((n == 0) ? -1 : -2);
    endfunction

    function automatic logic [DW-1:0] rand_op();
        logic [DW-1:0] v;
        case ($urandom_range(0, 5))
            0: v = {1'b1, {(DW-1){1'b0}}};
            1: v = {1'b0, {(DW-1){1'b1}}};
            2: v = '0;
            3: v = '1;
            4: v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_free = 1; m_pend = 0; m_rv = 0;
        m_opid = '0; m_id = '0; m_diff = '0; m_ovf = 1'b0;
        m_a = '0; m_b = '0;
    endtask

    function automatic int model_pick();
        if (!m_free) return -1;
        for (int d = 0; d < NR; d++) if (req_valid[(m_rr + d) % NR]) return (m_rr + d) % NR;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = pend[i];
            req_a[i*DW +: DW] = a_r[i];
            req_b[i*DW +: DW] = b_r[i];
        end
    endtask

    // Called at a falling edge with inputs already applied; checks, then advances one clock.
    task automatic cyc();
        int g;
        logic [NR-1:0] er;
        logic signed [DW:0] full;
        #1;
        g  = model_pick();
        er = (g >= 0) ? (NR'(1) << g) : '0;
        check("req_ready", req_ready, er);
        check("busy", busy, !m_free);
        check("rsp_valid", rsp_valid, m_rv);
        check("rsp_id", rsp_id, m_id);
        check("rsp_diff", rsp_diff, m_diff);
        check("rsp_ovf", rsp_ovf, m_ovf);
        obs_gnt = onehot_idx(req_ready);
        if (g >= 0) begin
            m_a = req_a[g*DW +: DW];
            m_b = req_b[g*DW +: DW];
            m_opid = g[IW-1:0];
            m_rr = (g + 1) % NR;
            m_free = 0;
            m_pend = 1;
        end else if (m_pend) begin
            full = $signed({m_a[DW-1], m_a}) - $signed({m_b[DW-1], m_b});
            m_diff = full[DW-1:0];
            m_ovf = (full > SMAX) || (full < SMIN);
            m_id = m_opid;
            m_rv = 1;
            m_pend = 0;
        end else if (m_rv && rsp_ready) begin
            m_rv = 0;
            m_free = 1;
        end
        cyc_no++;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        #2;
        model_reset();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_diff", rsp_diff, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_ovf", rsp_ovf, 0);
        check("rst_req_ready", req_ready, 0);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) pend[i] = 0;
        drive();
    endtask

    initial begin
        Rst = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 0; a_r[i] = '0; b_r[i] = '0; wait_cnt[i] = 0;
        end
        drive();
        model_reset();
        @(negedge Clk);
        do_reset();

        // reset in the middle of an operation
        pend[2] = 1; a_r[2] = 64'd10; b_r[2] = 64'd3; drive();
        cyc();
        clear_all();
        #1 check("t1_busy_calc", busy, 1);
        do_reset();
        repeat (4) cyc();
        pend[1] = 1; pend[3] = 1; a_r[1] = 64'd7; b_r[1] = 64'd2; drive();
        #1 check("t1_search_from0", req_ready, 4'b0010);
        cyc();
        clear_all();
        cyc(); cyc();

        // single request
        pend[1] = 1; a_r[1] = 64'd100; b_r[1] = -64'sd25; drive();
        #1 check("t2_ready", req_ready, 4'b0010);
        cyc();
        clear_all();
        cyc();
        #1;
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_id", rsp_id, 1);
        check("t2_rsp_diff", rsp_diff, 64'd125);
        check("t2_rsp_ovf", rsp_ovf, 0);
        cyc();

        // all requesters continuously valid
        clear_all();
        do_reset();
        for (int i = 0; i < NR; i++) begin pend[i] = 1; a_r[i] = rand_op(); b_r[i] = rand_op(); end
        drive();
        for (int c = 0; c < 15; c++) begin
            cyc();
            if (obs_gnt >= 0) begin
                gq.push_back(obs_gnt);
                tq.push_back(cyc_no);
                a_r[obs_gnt] = rand_op(); b_r[obs_gnt] = rand_op();
                drive();
            end
        end
        check("t3_grant_count", gq.size(), 5);
        for (int k = 0; k < gq.size() && k < 5; k++) begin
            check("t3_grant_order", gq[k], k % NR);
            if (k > 0) check("t3_interval", tq[k] - tq[k-1], 3);
        end
        clear_all();
        cyc(); cyc();

        // overflow boundaries
        pend[0] = 1; a_r[0] = 64'h8000_0000_0000_0000; b_r[0] = 64'd1; drive();
        cyc(); clear_all(); cyc();
        #1;
        check("t4_min_minus1_diff", rsp_diff, 64'h7FFF_FFFF_FFFF_FFFF);
        check("t4_min_minus1_ovf", rsp_ovf, 1);
        cyc();
        pend[0] = 1; a_r[0] = '1; b_r[0] = '1; drive();
        cyc(); clear_all(); cyc();
        #1;
        check("t4_m1_minus_m1_diff", rsp_diff, 0);
        check("t4_m1_minus_m1_ovf", rsp_ovf, 0);
        cyc();

        // response backpressure
        pend[3] = 1; a_r[3] = 64'd50; b_r[3] = 64'd8; drive();
        rsp_ready = 1'b0;
        cyc();
        pend[3] = 0; pend[0] = 1; a_r[0] = 64'd9; b_r[0] = 64'd4; drive();
        cyc();
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t5_busy", busy, 1);
            check("t5_req_ready", req_ready, 0);
            check("t5_rsp_id", rsp_id, 3);
            check("t5_rsp_diff", rsp_diff, 64'd42);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        #1 check("t5_next_grant", req_ready, 4'b0001);
        cyc();
        clear_all();
        cyc(); cyc();

        // wrap of the round-robin pointer
        pend[1] = 1; a_r[1] = 64'd1; b_r[1] = 64'd1; drive();
        cyc(); clear_all(); cyc(); cyc();
        pend[0] = 1; pend[1] = 1; a_r[0] = 64'd5; b_r[0] = 64'd6; drive();
        #1 check("t6_wrap_grant0", req_ready, 4'b0001);
        cyc();
        pend[0] = 0; drive();
        cyc(); cyc();
        #1 check("t6_then_grant1", req_ready, 4'b0010);
        cyc();
        clear_all();
        cyc(); cyc();

        // randomized traffic with legal request withdrawal
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1; a_r[i] = rand_op(); b_r[i] = rand_op(); wait_cnt[i] = 0;
                end else if (pend[i] && $urandom_range(0, 29) == 0) begin
                    pend[i] = 0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            drive();
            cyc();
            if (obs_gnt >= 0) begin
                check("fairness", wait_cnt[obs_gnt] <= NR - 1, 1);
                for (int i = 0; i < NR; i++) if (pend[i] && i != obs_gnt) wait_cnt[i]++;
                pend[obs_gnt] = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
